// File: rtl/seg_pkg.sv
// Shared types, constants and the leading-zero helper for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {BLANK, SHOW} scan_state_e;

  typedef logic [3:0] bcd_t;

  // Bit i set means digit i is a leading zero and should be blanked.
  // Supports up to 8 digits; only the low n nibbles are considered.
  function automatic logic [7:0] lz_mask(input logic [31:0] digits, input int n);
    logic [7:0] mask;
    logic       seen;
    mask = '0;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        if (digits[4*i +: 4] != 4'd0) seen = 1'b1;
        mask[i] = !seen && (i != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder, output order {a,b,c,d,e,f,g}.
module bcd_to_7seg
  import seg_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0: seg_n = 7'b0000001;
      4'd1: seg_n = 7'b1001111;
      4'd2: seg_n = 7'b0010010;
      4'd3: seg_n = 7'b0000110;
      4'd4: seg_n = 7'b1001100;
      4'd5: seg_n = 7'b0100100;
      4'd6: seg_n = 7'b0100000;
      4'd7: seg_n = 7'b0001111;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0000100;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl_timer.sv
// Free-running tick counter that restarts itself at a caller-selected terminal count.
module seg_scan_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (tc)  cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, blanking gaps between
// digits, and display values that only change on frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    lz_blank_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    frame_done
);

  localparam int MAX_T = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CW    = $clog2(MAX_T);
  localparam int IW    = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_e             state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [CW-1:0]           last;
  logic                    tc;
  logic [4*NUM_DIGITS-1:0] active, pending;
  logic                    pending_full;
  logic [NUM_DIGITS-1:0]   mask;
  bcd_t                    cur_nib, dec_in;
  logic                    cur_mask;
  logic [6:0]              dec_seg, show_seg;

  assign last = (state == SHOW) ? SHOW_LAST : BLANK_LAST;

  seg_scan_ctrl_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .last    (last),
    .tc      (tc)
  );

  // Select the nibble and leading-zero flag of the digit about to be lit.
  assign mask = NUM_DIGITS'(lz_mask(32'(active), NUM_DIGITS));

  always_comb begin
    cur_nib  = '0;
    cur_mask = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib  = active[4*i +: 4];
        cur_mask = mask[i];
      end
    end
  end

  // Out-of-range nibbles never reach the decoder; they are blanked instead.
  assign dec_in = (cur_nib > 4'd9) ? 4'd0 : cur_nib;

  bcd_to_7seg u_dec (
    .bcd   (dec_in),
    .seg_n (dec_seg)
  );

  assign show_seg = ((cur_nib > 4'd9) || (lz_blank_en && cur_mask)) ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BLANK;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    frame_done = 1'b0;
    if (tc) begin
      case (state)
        BLANK: state_nx = SHOW;
        SHOW: begin
          state_nx   = BLANK;
          idx_nx     = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          frame_done = (idx == IDX_LAST);
        end
        default: state_nx = BLANK;
      endcase
    end
  end

  // Pin drivers are loaded with the next state's values so they switch cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n    <= SEG_BLANK;
      dig_en_n <= '1;
    end else if (tc) begin
      if (state == BLANK) begin
        seg_n    <= show_seg;
        dig_en_n <= ~(NUM_DIGITS'(1) << idx);
      end else begin
        seg_n    <= SEG_BLANK;
        dig_en_n <= '1;
      end
    end
  end

  assign load_ready = !pending_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      active       <= '0;
      pending_full <= 1'b0;
    end else begin
      if (load_valid && load_ready) begin
        pending      <= digits_in;
        pending_full <= 1'b1;
      end
      if (frame_done && pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end
    end
  end

endmodule
